// File: rtl/udp_port_demux.sv
// udp_port_demux: routes one UDP receive stream to one of M_COUNT outputs by
// matching the destination port against a runtime port table.
// Optional feature macro: UDP_PORT_DEMUX_CATCHALL_EN. When it is defined,
// unmatched frames go to output M_COUNT-1 and that output is removed from the
// port table. When it is undefined, unmatched frames are discarded.
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where both
// are high. A valid, once raised, is held with stable data until it transfers.
// Header and payload channels are independent of each other.
module udp_port_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int META_WIDTH  = 96
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    s_udp_hdr_valid,
  output logic                    s_udp_hdr_ready,
  input  logic [15:0]             s_udp_dest_port,
  input  logic [META_WIDTH-1:0]   s_udp_hdr_meta,
  input  logic [DATA_WIDTH-1:0]   s_udp_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_udp_payload_axis_tkeep,
  input  logic                    s_udp_payload_axis_tvalid,
  output logic                    s_udp_payload_axis_tready,
  input  logic                    s_udp_payload_axis_tlast,
  input  logic                    s_udp_payload_axis_tuser,

  output logic [M_COUNT-1:0]      m_udp_hdr_valid,
  input  logic [M_COUNT-1:0]      m_udp_hdr_ready,
  output logic [15:0]             m_udp_dest_port,
  output logic [META_WIDTH-1:0]   m_udp_hdr_meta,
  output logic [DATA_WIDTH-1:0]   m_udp_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_udp_payload_axis_tkeep,
  output logic [M_COUNT-1:0]      m_udp_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]      m_udp_payload_axis_tready,
  output logic                    m_udp_payload_axis_tlast,
  output logic                    m_udp_payload_axis_tuser,

  input  logic [M_COUNT*16-1:0]   cfg_port_table,
  input  logic [M_COUNT-1:0]      cfg_port_enable,

  output logic                    busy,
  output logic                    stat_drop,
  output logic [1:0]              dbg_state
);

  localparam int SEL_WIDTH = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
`ifdef UDP_PORT_DEMUX_CATCHALL_EN
  localparam int  MATCH_LIMIT = M_COUNT - 1;
  localparam bit  CATCHALL    = 1'b1;
`else
  localparam int  MATCH_LIMIT = M_COUNT;
  localparam bit  CATCHALL    = 1'b0;
`endif
  localparam logic [M_COUNT-1:0]   ONE_BIT  = 1;
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(M_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [M_COUNT-1:0]      hdr_valid_q, hdr_valid_d;
  logic [15:0]             dest_port_q, dest_port_d;
  logic [META_WIDTH-1:0]   meta_q, meta_d;
  logic                    stat_drop_q, stat_drop_d;

  logic                    match_found;
  logic [SEL_WIDTH-1:0]    match_idx;
  logic                    hdr_accept;
  logic                    routed;
  logic [SEL_WIDTH-1:0]    route_idx;
  logic                    beat_xfer;
  logic [M_COUNT-1:0]      sel_onehot;

  // A new header is taken only when idle and the previous header has left.
  assign s_udp_hdr_ready = !rst && (state_q == ST_IDLE) && (hdr_valid_q == '0);
  assign hdr_accept      = s_udp_hdr_valid && s_udp_hdr_ready;
  assign beat_xfer       = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
  assign sel_onehot      = ONE_BIT << sel_q;

  // Lowest enabled table entry equal to the incoming port wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (i < MATCH_LIMIT && !match_found && cfg_port_enable[i] &&
          cfg_port_table[16*i +: 16] == s_udp_dest_port) begin
        match_found = 1'b1;
        match_idx   = SEL_WIDTH'(i);
      end
    end
  end

  // Unmatched traffic is either steered to the last output or discarded.
  always_comb begin
    routed    = match_found || CATCHALL;
    route_idx = match_found ? match_idx : LAST_SEL;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a frame ends on its tlast transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_accept) begin
          state_d = routed ? ST_PAYLOAD : ST_DROP;
        end
      end
      ST_PAYLOAD, ST_DROP: begin
        if (beat_xfer && s_udp_payload_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: payload steering and status.
  always_comb begin
    s_udp_payload_axis_tready = 1'b0;
    m_udp_payload_axis_tvalid = '0;
    case (state_q)
      ST_PAYLOAD: begin
        s_udp_payload_axis_tready = |(m_udp_payload_axis_tready & sel_onehot);
        m_udp_payload_axis_tvalid = {M_COUNT{s_udp_payload_axis_tvalid}} & sel_onehot;
      end
      ST_DROP: begin
        s_udp_payload_axis_tready = 1'b1;
      end
      default: begin
        s_udp_payload_axis_tready = 1'b0;
      end
    endcase
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
  end

  // Header-side registers: latch route, key and sideband on accept.
  always_comb begin
    sel_d       = sel_q;
    hdr_valid_d = hdr_valid_q & ~m_udp_hdr_ready;
    dest_port_d = dest_port_q;
    meta_d      = meta_q;
    stat_drop_d = 1'b0;
    if (hdr_accept) begin
      dest_port_d = s_udp_dest_port;
      meta_d      = s_udp_hdr_meta;
      if (routed) begin
        sel_d       = route_idx;
        hdr_valid_d = ONE_BIT << route_idx;
      end else begin
        stat_drop_d = 1'b1;
      end
    end
  end

  // Header-side register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      hdr_valid_q <= '0;
      dest_port_q <= '0;
      meta_q      <= '0;
      stat_drop_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      hdr_valid_q <= hdr_valid_d;
      dest_port_q <= dest_port_d;
      meta_q      <= meta_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign m_udp_hdr_valid          = hdr_valid_q;
  assign m_udp_dest_port          = dest_port_q;
  assign m_udp_hdr_meta           = meta_q;
  assign stat_drop                = stat_drop_q;
  assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
  assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
  assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;
  assign m_udp_payload_axis_tkeep = (KEEP_ENABLE != 0) ? s_udp_payload_axis_tkeep
                                                       : {KEEP_WIDTH{1'b1}};

endmodule
